wb_ram_arbiter: RTL and testbench

//  Shares the single user-RAM Wishbone slave port between three masters:
//  the CPU (m0), the DMA input engine feeding the FIR (m1) and the DMA output

---
 rtl/wb_ram_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_ram_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter.sv
// rtl/wb_ram_arbiter.sv - three-master Wishbone arbiter for the shared user-RAM slave port
module wb_ram_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  m_cyc,
  input  logic [2:0]  m_stb,
  input  logic [2:0]  m_we,
  input  logic [11:0] m_sel,
  input  logic [95:0] m_adr,
  input  logic [95:0] m_dat_w,
  output logic [2:0]  m_ack,
  output logic [2:0]  m_err,
  output logic [31:0] m_dat_r,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_w,
  input  logic        s_ack,
  input  logic [31:0] s_dat_r,
  output logic [2:0]  grant
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT);

  state_t      state;
  logic [1:0]  last;
  logic [7:0]  timer;
  logic [2:0]  req;
  logic [1:0]  win_idx;
  logic [1:0]  g_idx;
  logic [1:0]  c1, c2;
  logic        busy;
  logic        timeout_hit;
  logic [3:0]  sel_g;
  logic [31:0] adr_g, dat_g;

  function automatic logic [1:0] next3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign req  = m_cyc & m_stb;
  assign busy = (state == BUSY);
  assign c1   = next3(last);
  assign c2   = next3(c1);

  always_comb begin
    win_idx = 2'd0;
    if (ROUND_ROBIN != 0) begin
      if (req[c1])      win_idx = c1;
      else if (req[c2]) win_idx = c2;
      else              win_idx = last;
    end else begin
      if (req[0])       win_idx = 2'd0;
      else if (req[1])  win_idx = 2'd1;
      else              win_idx = 2'd2;
    end
  end

  assign g_idx = grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);

  always_comb begin
    sel_g = m_sel[3:0];
    adr_g = m_adr[31:0];
    dat_g = m_dat_w[31:0];
    case (g_idx)
      2'd1: begin
        sel_g = m_sel[7:4];
        adr_g = m_adr[63:32];
        dat_g = m_dat_w[63:32];
      end
      2'd2: begin
        sel_g = m_sel[11:8];
        adr_g = m_adr[95:64];
        dat_g = m_dat_w[95:64];
      end
      default: ;
    endcase
  end

  // Slave side is a pure mux on the registered grant; everything is zero while idle.
  assign s_cyc   = busy & m_cyc[g_idx];
  assign s_stb   = busy & m_stb[g_idx];
  assign s_we    = busy & m_we[g_idx];
  assign s_sel   = busy ? sel_g : 4'd0;
  assign s_adr   = busy ? adr_g : 32'd0;
  assign s_dat_w = busy ? dat_g : 32'd0;

  assign timeout_hit = busy & (timer == TMO_LAST);
  assign m_ack   = (busy & s_ack) ? grant : 3'd0;
  assign m_err   = (busy & ~s_ack & m_cyc[g_idx] & timeout_hit) ? grant : 3'd0;
  assign m_dat_r = busy ? s_dat_r : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 3'd0;
      last  <= 2'd2;
      timer <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= 3'b001 << win_idx;
            state <= BUSY;
            timer <= 8'd0;
          end
        end
        BUSY: begin
          // Completion, abort and timeout all release the port the same way.
          if (s_ack || !m_cyc[g_idx] || timeout_hit) begin
            state <= IDLE;
            grant <= 3'd0;
            last  <= g_idx;
          end else if (timer != TMO_MAX) begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb/tb_wb_ram_arbiter.sv - directed bench for wb_ram_arbiter (round-robin and fixed-priority instances)
module tb_wb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  m_cyc = '0, m_stb = '0, m_we = '0;
  logic [11:0] m_sel = '0;
  logic [95:0] m_adr = '0, m_dat_w = '0;
  logic        s_ack;
  logic [31:0] s_dat_r = '0;
  logic        ack_man = 1'b0;
  logic [1:0]  ack_src = 2'd0;

  logic [2:0]  rr_m_ack, rr_m_err, rr_grant;
  logic [31:0] rr_m_dat_r, rr_s_adr, rr_s_dat_w;
  logic        rr_s_cyc, rr_s_stb, rr_s_we;
  logic [3:0]  rr_s_sel;

  logic [2:0]  fp_m_ack, fp_m_err, fp_grant;
  logic [31:0] fp_m_dat_r, fp_s_adr, fp_s_dat_w;
  logic        fp_s_cyc, fp_s_stb, fp_s_we;
  logic [3:0]  fp_s_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // RAM stand-in: either manual ack or a same-cycle ack following one instance's stb.
  always_comb begin
    s_ack = ack_man;
    if (ack_src == 2'd1) s_ack = rr_s_stb;
    else if (ack_src == 2'd2) s_ack = fp_s_stb;
  end

  wb_ram_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_ack(rr_m_ack), .m_err(rr_m_err), .m_dat_r(rr_m_dat_r),
    .s_cyc(rr_s_cyc), .s_stb(rr_s_stb), .s_we(rr_s_we), .s_sel(rr_s_sel), .s_adr(rr_s_adr),
    .s_dat_w(rr_s_dat_w), .s_ack(s_ack), .s_dat_r(s_dat_r), .grant(rr_grant)
  );

  wb_ram_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(8)) dut_fp (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_ack(fp_m_ack), .m_err(fp_m_err), .m_dat_r(fp_m_dat_r),
    .s_cyc(fp_s_cyc), .s_stb(fp_s_stb), .s_we(fp_s_we), .s_sel(fp_s_sel), .s_adr(fp_s_adr),
    .s_dat_w(fp_s_dat_w), .s_ack(s_ack), .s_dat_r(s_dat_r), .grant(fp_grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; ack_man = 1'b0; ack_src = 2'd0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rr_grant !== 3'b000) begin $display("FAIL reset_grant: got %b expected 000", rr_grant); n_fail++; end
    n_checks++; if ({rr_s_cyc, rr_s_stb, rr_s_we, rr_s_sel} !== 7'd0) begin $display("FAIL reset_s_ctl: got %b expected 0", {rr_s_cyc, rr_s_stb, rr_s_we, rr_s_sel}); n_fail++; end
    n_checks++; if (rr_s_adr !== 32'd0) begin $display("FAIL reset_s_adr: got %h expected 0", rr_s_adr); n_fail++; end
    n_checks++; if ({rr_m_ack, rr_m_err} !== 6'd0) begin $display("FAIL reset_ack_err: got %b expected 0", {rr_m_ack, rr_m_err}); n_fail++; end
    n_checks++; if (rr_m_dat_r !== 32'd0) begin $display("FAIL reset_dat_r: got %h expected 0", rr_m_dat_r); n_fail++; end
    n_checks++; if (fp_grant !== 3'b000) begin $display("FAIL reset_fp_grant: got %b expected 000", fp_grant); n_fail++; end
  endtask

  task automatic test_single_read();
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001; m_we = 3'b000; m_sel = 12'h00F;
    m_adr[31:0] = 32'h3800_0010;
    n_checks++; if (rr_s_stb !== 1'b0) begin $display("FAIL read_c0_stb: got %b expected 0", rr_s_stb); n_fail++; end
    tick();
    n_checks++; if (rr_s_stb !== 1'b1) begin $display("FAIL read_c1_stb: got %b expected 1", rr_s_stb); n_fail++; end
    n_checks++; if (rr_s_adr !== 32'h3800_0010) begin $display("FAIL read_c1_adr: got %h expected 38000010", rr_s_adr); n_fail++; end
    n_checks++; if (rr_grant !== 3'b001) begin $display("FAIL read_c1_grant: got %b expected 001", rr_grant); n_fail++; end
    n_checks++; if (rr_m_ack !== 3'b000) begin $display("FAIL read_c1_ack: got %b expected 000", rr_m_ack); n_fail++; end
    tick();
    tick();
    ack_man = 1'b1; s_dat_r = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (rr_m_ack !== 3'b001) begin $display("FAIL read_c3_ack: got %b expected 001", rr_m_ack); n_fail++; end
    n_checks++; if (rr_m_dat_r !== 32'hDEAD_BEEF) begin $display("FAIL read_c3_dat: got %h expected deadbeef", rr_m_dat_r); n_fail++; end
    tick();
    ack_man = 1'b0; m_cyc = '0; m_stb = '0;
    n_checks++; if (rr_grant !== 3'b000) begin $display("FAIL read_c4_grant: got %b expected 000", rr_grant); n_fail++; end
    n_checks++; if (rr_s_cyc !== 1'b0) begin $display("FAIL read_c4_cyc: got %b expected 0", rr_s_cyc); n_fail++; end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    do_reset();
    ack_src = 2'd1;
    m_cyc = 3'b111; m_stb = 3'b111;
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_g = (k % 2 == 0) ? (3'b001 << ((k / 2) % 3)) : 3'b000;
      n_checks++; if (rr_grant !== exp_g) begin $display("FAIL rr_grant[%0d]: got %b expected %b", k, rr_grant, exp_g); n_fail++; end
      n_checks++; if (rr_m_ack !== exp_g) begin $display("FAIL rr_ack[%0d]: got %b expected %b", k, rr_m_ack, exp_g); n_fail++; end
    end
    m_cyc = '0; m_stb = '0; ack_src = 2'd0;
    tick();
  endtask

  task automatic test_fixed_priority();
    logic [2:0] exp_g;
    do_reset();
    ack_src = 2'd2;
    m_cyc = 3'b110; m_stb = 3'b110;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_g = (k % 2 == 0) ? 3'b010 : 3'b000;
      n_checks++; if (fp_grant !== exp_g) begin $display("FAIL fp_grant[%0d]: got %b expected %b", k, fp_grant, exp_g); n_fail++; end
    end
    m_cyc = 3'b100; m_stb = 3'b100;
    tick();
    n_checks++; if (fp_grant !== 3'b100) begin $display("FAIL fp_m2_grant: got %b expected 100", fp_grant); n_fail++; end
    n_checks++; if (fp_m_ack !== 3'b100) begin $display("FAIL fp_m2_ack: got %b expected 100", fp_m_ack); n_fail++; end
    m_cyc = '0; m_stb = '0; ack_src = 2'd0;
    tick();
  endtask

  task automatic test_timeout();
    logic [2:0] exp_err, exp_g;
    do_reset();
    m_cyc = 3'b100; m_stb = 3'b100; m_we = 3'b100; m_sel = 12'hF00;
    m_adr[95:64] = 32'h3800_0040; m_dat_w[95:64] = 32'h1234_5678;
    for (int c = 1; c <= 9; c++) begin
      tick();
      exp_err = (c == 8) ? 3'b100 : 3'b000;
      exp_g   = (c <= 8) ? 3'b100 : 3'b000;
      n_checks++; if (rr_m_err !== exp_err) begin $display("FAIL tmo_err[%0d]: got %b expected %b", c, rr_m_err, exp_err); n_fail++; end
      n_checks++; if (rr_m_ack !== 3'b000) begin $display("FAIL tmo_ack[%0d]: got %b expected 000", c, rr_m_ack); n_fail++; end
      n_checks++; if (rr_grant !== exp_g) begin $display("FAIL tmo_grant[%0d]: got %b expected %b", c, rr_grant, exp_g); n_fail++; end
      if (c == 1) begin
        n_checks++; if ({rr_s_we, rr_s_dat_w} !== {1'b1, 32'h1234_5678}) begin $display("FAIL tmo_wdata: got %b/%h expected 1/12345678", rr_s_we, rr_s_dat_w); n_fail++; end
      end
    end
    m_cyc = '0; m_stb = '0; m_we = '0;
    tick();
  endtask

  task automatic test_abort_reset();
    do_reset();
    m_cyc = 3'b010; m_stb = 3'b010; m_adr[63:32] = 32'h3800_0020;
    tick();
    n_checks++; if ({rr_grant, rr_s_cyc} !== 4'b0101) begin $display("FAIL abort_c1: got %b expected 0101", {rr_grant, rr_s_cyc}); n_fail++; end
    m_cyc = '0; m_stb = '0;
    tick();
    n_checks++; if ({rr_grant, rr_s_cyc} !== 4'b0000) begin $display("FAIL abort_c2: got %b expected 0000", {rr_grant, rr_s_cyc}); n_fail++; end
    n_checks++; if ({rr_m_ack, rr_m_err} !== 6'd0) begin $display("FAIL abort_ack_err: got %b expected 0", {rr_m_ack, rr_m_err}); n_fail++; end
    m_cyc = 3'b001; m_stb = 3'b001; m_adr[31:0] = 32'h3800_0030;
    tick();
    n_checks++; if (rr_grant !== 3'b001) begin $display("FAIL rst_pre_grant: got %b expected 001", rr_grant); n_fail++; end
    rst = 1'b1;
    tick();
    n_checks++; if (rr_grant !== 3'b000) begin $display("FAIL rst_mid_grant: got %b expected 000", rr_grant); n_fail++; end
    n_checks++; if ({rr_s_cyc, rr_s_stb, rr_s_adr} !== 34'd0) begin $display("FAIL rst_mid_s: got %b/%b/%h expected 0", rr_s_cyc, rr_s_stb, rr_s_adr); n_fail++; end
    n_checks++; if (rr_m_ack !== 3'b000) begin $display("FAIL rst_mid_ack: got %b expected 000", rr_m_ack); n_fail++; end
    rst = 1'b0; m_cyc = 3'b111; m_stb = 3'b111;
    tick();
    n_checks++; if (rr_grant !== 3'b001) begin $display("FAIL rst_next_grant: got %b expected 001", rr_grant); n_fail++; end
    m_cyc = '0; m_stb = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_abort_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
